seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Time-multiplexed scan controller for the four-digit display path of the multiplier. It latches a 16-bit result and rotates a one-hot digit select through 1000 → 0100 → 0010 → 0001 at a programmable rate. It presents the matching nibble and active-low anode enables for each digit. It is the producing end of the one-hot select/data interface: its `sel` and `digit` outputs drive the one-hot 4:1 digit mux and the 7-segment decoder, and its `an` output drives the board anodes.

## Interface
Parameters:
- `DIV`, default 100000: clocks per digit dwell. Legal range is ≥ 1.
- `CNT_W`, default 17: prescaler width. It must satisfy 2^CNT_W > DIV-1.

Ports:
- `clk`  in  1  single system clock. All logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  one-cycle strobe; captures `din`.
- `din`  in  16  value to display; [15:12] is the leftmost digit.
- `blank_lz`  in  1  when 1, leading-zero digits are blanked.
- `sel`  out  4  one-hot digit select. 1000 selects the leftmost digit (bits [15:12]).
- `digit`  out  4  nibble for the currently selected digit.
- `an`  out  4  active-low anode enables, one per digit.
- `frame`  out  1  one-cycle pulse at the start of each scan frame.
- `pending`  out  1  a loaded value is waiting to be committed.

## Operation
- Registers:
  - prescaler `cnt` [CNT_W-1:0]
  - `sel`
  - displayed value `val` [15:0]
  - shadow `shd` [15:0]
  - `pending`
- Prescaler: `cnt` counts 0..DIV-1. When `cnt`==DIV-1 it wraps to 0, called a "tick".
  - With DIV=1, every cycle is a tick.
- On a tick, `sel` rotates right: 1000→0100→0010→0001→1000. No other `sel` value is ever reachable after reset.
- Frame start: a tick while `sel`==0001, so that `sel` becomes 1000 next.
  - `frame`=1 for exactly that following cycle, aligned with `sel`==1000.
- Load/commit (tear-free):
  - `load`=1: `shd`←`din`, `pending`←1.
  - At frame start with `pending`=1: `val`←`shd`, `pending`←0. `val` changes only at frame start.
  - `load` in the same cycle as frame start: `val`←`din` directly, and `pending`←0.
  - Back-to-back loads within one frame: the last one wins.
- Digit mapping, combinational from the registered `sel` and `val`:
  - 1000→`val`[15:12]
  - 0100→[11:8]
  - 0010→[7:4]
  - 0001→[3:0]
  - `digit` and `sel` are therefore consistent in every cycle.
- Anodes: `an` = ~`sel`, unless the selected digit is blanked, in which case `an`=1111.
- Blanking, when `blank_lz`=1:
  - Digit k (k=3 is leftmost) is blanked iff it and all digits left of it in `val` are 0.
  - Digit 0 is never blanked, so `val`=0 shows a single "0".
  - When `blank_lz`=0, no digit is blanked.
- Reset values:
  - `cnt`=0, `sel`=1000, `val`=0, `shd`=0, `pending`=0
  - outputs: `digit`=0, `an`=0111, `frame`=0
  - `rst` has priority over `load` and tick.
- Reset mid-frame discards any pending value and restarts the scan at digit 3.

## Timing
- Each digit is held exactly DIV clocks; one frame is 4·DIV clocks.
- Load-to-display latency: from the cycle after `load` up to the next frame start, at most 4·DIV clocks.
- `sel` and `frame` change only on the clock edge following a tick.
- `an`/`digit` transitions are glitch-free relative to `sel`: all derive from registers through one mux level.
- `pending` is visible the cycle after `load` and clears the cycle after the commit.
- First frame after reset:
  - Cycles 0..DIV-1 show digit 3.
  - The first `frame` pulse occurs 4·DIV cycles after reset is released.

## Test plan
All scenarios use DIV=4.
- **Reset:** hold `rst` 3 cycles, then release → `sel`=1000, `an`=0111, `digit`=0, `pending`=0, `frame`=0. `sel`=0100 appears 4 clocks after release.
- **Rotation:** free-run 32 clocks → `sel` sequence 1000,0100,0010,0001 repeated, each held 4 clocks. `frame` pulses once every 16 clocks, aligned with `sel`=1000.
- **Tear-free load:** `load` with `din`=16'h1234 while `sel`=0100 → `pending`=1 and `val` is unchanged through the frame. At the next frame start `digit` reads 1,2,3,4 across the digits and `pending`=0.
- **Simultaneous load and frame start:** `load` with `din`=16'hBEEF on the frame-start cycle → the next frame shows B,E,E,F and `pending` stays 0. Then `load` 16'h0001 and 16'h0002 in the same frame → only 0002 is committed.
- **Leading-zero blanking:** `val`=16'h0040 with `blank_lz`=1 → `an`=1111 on digits 3 and 2, `an`=1101 on digit 1 showing 4, `an`=1110 on digit 0 showing 0. With `val`=0, only digit 0 is lit.
- **Reset mid-operation:** `load` 16'hAAAA, then assert `rst` before frame start → `val`=0, `pending`=0, `sel`=1000, and 16'hAAAA is never displayed.

Source files
------------

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed scan controller for a four-digit seven-segment display.
// A 16-bit value is captured into a shadow register on `load` and committed to
// the displayed register only at the start of a scan frame, so a frame never
// shows a mix of old and new digits. A one-hot digit select walks from the
// leftmost digit to the rightmost, dwelling DIV clocks on each.
//
// Parameters:
//   DIV      clocks per digit dwell (>= 1)
//   CNT_W    prescaler width, 2**CNT_W must exceed DIV-1
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   rst       synchronous active-high reset
//   load      one-cycle strobe capturing din
//   din       value to display, [15:12] is the leftmost digit
//   blank_lz  blank leading-zero digits when 1
//   sel       one-hot digit select, 1000 = leftmost digit
//   digit     nibble of the currently selected digit
//   an        active-low anode enables (all high when the digit is blanked)
//   frame     one-cycle pulse aligned with the first digit of each frame
//   pending   a loaded value is waiting for the next frame start
// -----------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int DIV   = 100000,
  parameter int CNT_W = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] din,
  input  logic        blank_lz,
  output logic [3:0]  sel,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        frame,
  output logic        pending
);

  // The scan position is held directly in its one-hot form so that sel is a
  // plain register output with no decode between flop and pin.
  typedef enum logic [3:0] {
    DIG3 = 4'b1000,
    DIG2 = 4'b0100,
    DIG1 = 4'b0010,
    DIG0 = 4'b0001
  } scan_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  scan_t       scan_q;
  scan_t       scan_d;
  logic [CNT_W-1:0] cnt;
  logic        tick;
  logic        frame_start;
  logic [15:0] val;
  logic [15:0] shd;
  logic [3:0]  blank;
  logic        sel_blanked;

  assign tick        = (cnt == CNT_MAX);
  assign frame_start = tick && (scan_q == DIG0);

  // Prescaler: counts 0..DIV-1 and wraps; the wrap cycle is the tick that
  // advances the scan. With DIV=1 the counter sits at zero and every cycle
  // is a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Scan state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q <= DIG3;
    end else begin
      scan_q <= scan_d;
    end
  end

  // Next scan position: rotate right on a tick, hold otherwise. The default
  // arm returns to the leftmost digit should the register ever be corrupted.
  always_comb begin
    scan_d = scan_q;
    if (tick) begin
      case (scan_q)
        DIG3:    scan_d = DIG2;
        DIG2:    scan_d = DIG1;
        DIG1:    scan_d = DIG0;
        DIG0:    scan_d = DIG3;
        default: scan_d = DIG3;
      endcase
    end
  end

  // The frame pulse is registered from the frame-start tick, so it lands in
  // the same cycle the select returns to the leftmost digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame <= 1'b0;
    end else begin
      frame <= frame_start;
    end
  end

  // Load/commit path. A load coinciding with frame start bypasses the shadow
  // and goes straight to the displayed value; otherwise loads park in the
  // shadow (later loads overwrite earlier ones) until the next frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      val     <= '0;
      shd     <= '0;
      pending <= 1'b0;
    end else if (load && frame_start) begin
      val     <= din;
      shd     <= din;
      pending <= 1'b0;
    end else if (load) begin
      shd     <= din;
      pending <= 1'b1;
    end else if (frame_start && pending) begin
      val     <= shd;
      pending <= 1'b0;
    end
  end

  // Digit mux driven only by registers, so digit always matches sel.
  always_comb begin
    digit = '0;
    case (scan_q)
      DIG3:    digit = val[15:12];
      DIG2:    digit = val[11:8];
      DIG1:    digit = val[7:4];
      DIG0:    digit = val[3:0];
      default: digit = '0;
    endcase
  end

  // Leading-zero detection: a digit is blanked when it and every digit to its
  // left are zero. The rightmost digit is never blanked so zero shows as "0".
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (val[15:12] == 4'h0);
    blank[2] = blank[3] && (val[11:8] == 4'h0);
    blank[1] = blank[2] && (val[7:4] == 4'h0);
    blank[0] = 1'b0;
    if (!blank_lz) begin
      blank = 4'b0000;
    end
  end

  assign sel_blanked = |(blank & scan_q);
  assign sel         = scan_q;
  assign an          = sel_blanked ? 4'b1111 : ~scan_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Self-checking bench for seg_scan_driver with DIV=4. A reference model keeps
// the cycle count since reset release plus the displayed/shadow/pending values
// and derives the expected select, digit, anodes and frame pulse from that
// count with plain arithmetic. Directed scenarios are followed by a random run.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] din;
  logic        blank_lz;
  logic [3:0]  sel;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        frame;
  logic        pending;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int          t;
  logic [15:0] mval;
  logic [15:0] mshd;
  logic        mpend;
  bit          mvalid = 1'b0;

  seg_scan_driver #(.DIV(DIV), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .din      (din),
    .blank_lz (blank_lz),
    .sel      (sel),
    .digit    (digit),
    .an       (an),
    .frame    (frame),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s at t=%0d: got %h expected %h", tag, t, obs, exp);
    end
  endtask

  // Expected outputs for the current cycle from the model state.
  task automatic checkAll();
    int pos;
    logic [3:0] esel;
    logic [3:0] edig;
    bit blanked;
    pos     = 3 - ((t / DIV) % 4);
    esel    = 4'(1 << pos);
    edig    = mval[pos*4 +: 4];
    blanked = blank_lz && (pos != 0) && ((mval >> (4 * pos)) == 16'h0);
    checkOutput("sel", {12'h0, sel}, {12'h0, esel});
    checkOutput("digit", {12'h0, digit}, {12'h0, edig});
    checkOutput("an", {12'h0, an}, blanked ? 16'h000F : {12'h0, ~esel});
    checkOutput("frame", {15'h0, frame}, {15'h0, (t > 0) && (t % FRAME == 0)});
    checkOutput("pending", {15'h0, pending}, {15'h0, mpend});
  endtask

  // Model update at a rising edge.
  task automatic modelStep(input logic r, input logic l, input logic [15:0] d);
    bit fs;
    if (r) begin
      t = 0; mval = 16'h0; mshd = 16'h0; mpend = 1'b0; mvalid = 1'b1;
    end else if (mvalid) begin
      fs = ((t % FRAME) == FRAME - 1);
      if (l && fs) begin
        mval = d; mpend = 1'b0;
      end else if (l) begin
        mshd = d; mpend = 1'b1;
      end else if (fs && mpend) begin
        mval = mshd; mpend = 1'b0;
      end
      t++;
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
  task automatic applyStimulus(input logic r, input logic l, input logic [15:0] d, input logic b);
    rst = r; load = l; din = d; blank_lz = b;
    #1;
    if (mvalid) checkAll();
    @(posedge clk);
    modelStep(r, l, d);
    @(negedge clk);
  endtask

  task automatic runIdle(input int n, input logic b);
    repeat (n) applyStimulus(1'b0, 1'b0, 16'h0, b);
  endtask

  // Advance until the cycle index within a frame equals ph (bounded).
  task automatic waitPhase(input int ph, input logic b);
    for (int i = 0; i < FRAME && (t % FRAME) != ph; i++) runIdle(1, b);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; din = 16'h0; blank_lz = 1'b0;

    // Reset held three cycles, then free-run rotation.
    repeat (3) applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    runIdle(34, 1'b0);

    // Tear-free load while the second digit is selected.
    waitPhase(5, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h1234, 1'b0);
    runIdle(FRAME + 4, 1'b0);

    // Load on the frame-start cycle, then two loads in one frame.
    waitPhase(FRAME - 1, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b0);
    runIdle(FRAME + 2, 1'b0);
    waitPhase(2, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0001, 1'b0);
    runIdle(5, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0002, 1'b0);
    runIdle(FRAME + 4, 1'b0);

    // Leading-zero blanking with a sparse value and with zero.
    applyStimulus(1'b0, 1'b1, 16'h0040, 1'b1);
    runIdle(2 * FRAME + 2, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0000, 1'b1);
    runIdle(2 * FRAME + 2, 1'b1);

    // Reset before a pending value is committed.
    waitPhase(3, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'hAAAA, 1'b0);
    runIdle(3, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0);
    runIdle(2 * FRAME + 3, 1'b0);

    // Randomised traffic with occasional resets and blanking changes.
    begin
      logic b;
      b = 1'b0;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(0, 31) == 0) b = ~b;
        applyStimulus(($urandom_range(0, 149) == 0),
                      ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom),
                      b);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
